// File: rtl/systolic_pkg.sv
// Shared dimensions and PE index mapping for the 4x4 weight-stationary systolic array.
package systolic_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 16;

  function automatic int pe_index(input int row, input int col);
    return row * N + col;
  endfunction

endpackage

// File: rtl/systolic_array_4x4_if.sv
// Control, weight-load and data bus of the systolic array; the controller drives it as master.
interface systolic_array_4x4_if;
  import systolic_pkg::*;

  logic              data_clear;
  logic              en_shift_right;
  logic              en_shift_bottom;
  logic [DATA_W-1:0] b_reg_array_flat   [0:N*N-1];
  logic              b_we_array_flat    [0:N*N-1];
  logic [DATA_W-1:0] a_left_in_flat     [0:N-1];
  logic [DATA_W-1:0] ps_top_in_flat     [0:N-1];
  logic [DATA_W-1:0] ps_bottom_out_flat [0:N-1];

  modport master (
    output data_clear, en_shift_right, en_shift_bottom,
    output b_reg_array_flat, b_we_array_flat, a_left_in_flat, ps_top_in_flat,
    input  ps_bottom_out_flat
  );

  modport slave (
    input  data_clear, en_shift_right, en_shift_bottom,
    input  b_reg_array_flat, b_we_array_flat, a_left_in_flat, ps_top_in_flat,
    output ps_bottom_out_flat
  );

endinterface

// File: rtl/systolic_pe.sv
// Single processing element: stationary weight, activation pass-through and MAC partial sum.
module systolic_pe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_clear,
  input  logic              en_shift_right,
  input  logic              en_shift_bottom,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] ps_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] ps_out
);

  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] product;

  // Product and sum both wrap to DATA_W bits; the MAC always sees pre-edge A and W.
  assign product = a_q * w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (w_we) begin
      w_q <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      p_q <= '0;
    end else if (data_clear) begin
      a_q <= '0;
      p_q <= '0;
    end else begin
      if (en_shift_right) begin
        a_q <= a_in;
      end
      if (en_shift_bottom) begin
        p_q <= ps_in + product;
      end
    end
  end

  assign a_out  = a_q;
  assign ps_out = p_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 grid of PEs: activations flow left to right, partial sums flow top to bottom.
module systolic_array_4x4 #(
  parameter int N      = 4,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_array_4x4_if.slave  bus
);
  import systolic_pkg::*;

  logic [DATA_W-1:0] a_q   [0:N-1][0:N-1];
  logic [DATA_W-1:0] p_q   [0:N-1][0:N-1];
  logic [DATA_W-1:0] a_src [0:N-1][0:N-1];
  logic [DATA_W-1:0] p_src [0:N-1][0:N-1];

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_src[r][c] = bus.a_left_in_flat[r];
      end else begin : g_a_inner
        assign a_src[r][c] = a_q[r][c-1];
      end

      if (r == 0) begin : g_p_edge
        assign p_src[r][c] = bus.ps_top_in_flat[c];
      end else begin : g_p_inner
        assign p_src[r][c] = p_q[r-1][c];
      end

      systolic_pe #(
        .DATA_W(DATA_W)
      ) u_pe (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_clear      (bus.data_clear),
        .en_shift_right  (bus.en_shift_right),
        .en_shift_bottom (bus.en_shift_bottom),
        .w_we            (bus.b_we_array_flat[pe_index(r, c)]),
        .w_in            (bus.b_reg_array_flat[pe_index(r, c)]),
        .a_in            (a_src[r][c]),
        .ps_in           (p_src[r][c]),
        .a_out           (a_q[r][c]),
        .ps_out          (p_q[r][c])
      );
    end
  end

  // Outputs come straight from the bottom-row registers, so there is no input-to-output path.
  for (genvar c = 0; c < N; c++) begin : g_out
    assign bus.ps_bottom_out_flat[c] = p_q[N-1][c];
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4 with hand-computed column outputs.
module tb_systolic_array_4x4;
  import systolic_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  systolic_array_4x4_if bus ();

  systolic_array_4x4 #(
    .N      (4),
    .DATA_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic checkColumns(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_v [0:3];
    exp_v = '{e0, e1, e2, e3};
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("%s col%0d", tag, c), bus.ps_bottom_out_flat[c], exp_v[c]);
    end
  endtask

  task automatic set_activations(input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] a2, input logic [15:0] a3);
    bus.a_left_in_flat = '{a0, a1, a2, a3};
  endtask

  task automatic set_partials(input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
    bus.ps_top_in_flat = '{p0, p1, p2, p3};
  endtask

  task automatic stage_weight(input int idx, input logic [15:0] value);
    bus.b_reg_array_flat[idx] = value;
    bus.b_we_array_flat[idx]  = 1'b1;
  endtask

  // Stage every weight as zero so the next edge overwrites the whole grid.
  task automatic stage_all_weights_zero();
    for (int i = 0; i < 16; i++) begin
      stage_weight(i, 16'h0000);
    end
  endtask

  // One clock edge with the given controls; staged weight writes are consumed by it.
  task automatic applyStimulus(input logic clr, input logic en_r, input logic en_b);
    bus.data_clear      = clr;
    bus.en_shift_right  = en_r;
    bus.en_shift_bottom = en_b;
    @(posedge clk);
    #1;
    bus.data_clear      = 1'b0;
    bus.en_shift_right  = 1'b0;
    bus.en_shift_bottom = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.b_we_array_flat[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.data_clear      = 1'b0;
    bus.en_shift_right  = 1'b0;
    bus.en_shift_bottom = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.b_reg_array_flat[i] = 16'h0000;
      bus.b_we_array_flat[i]  = 1'b0;
    end
    set_activations(0, 0, 0, 0);
    set_partials(0, 0, 0, 0);

    #1 rst_n = 1'b0;
    #1 checkColumns("reset", 0, 0, 0, 0);
    #10 rst_n = 1'b1;

    // Single MAC: 2*3 travels down column 0 in four bottom shifts.
    stage_weight(0, 16'd3);
    applyStimulus(0, 0, 0);
    set_activations(2, 0, 0, 0);
    applyStimulus(0, 1, 0);
    set_activations(0, 0, 0, 0);
    set_partials(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1);
    checkOutput("mac_latency col0", bus.ps_bottom_out_flat[0], 16'd0);
    applyStimulus(0, 0, 1);
    checkColumns("single_mac", 16'd6, 0, 0, 0);

    // Asynchronous reset with a nonzero bottom partial sum.
    #2 rst_n = 1'b0;
    #1 checkColumns("async_reset", 0, 0, 0, 0);
    #1 rst_n = 1'b1;

    // Column sum: 10 + 1 + 2 + 3 + 4.
    for (int r = 0; r < 4; r++) begin
      stage_weight(r * 4, 16'd1);
    end
    applyStimulus(0, 0, 0);
    set_activations(1, 2, 3, 4);
    applyStimulus(0, 1, 0);
    set_activations(0, 0, 0, 0);
    set_partials(10, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1);
    checkColumns("column_sum", 16'd20, 0, 0, 0);

    // Hold: inputs wiggle but no enable is set.
    set_partials(99, 99, 99, 99);
    set_activations(7, 7, 7, 7);
    repeat (10) applyStimulus(0, 0, 0);
    checkColumns("hold", 16'd20, 0, 0, 0);
    set_partials(10, 0, 0, 0);
    set_activations(0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1);
    checkOutput("hold_regs col0", bus.ps_bottom_out_flat[0], 16'd20);

    // Clear beats both enables; the simultaneous weight write still lands.
    stage_weight(1, 16'd5);
    set_activations(9, 9, 9, 9);
    set_partials(3, 3, 3, 3);
    applyStimulus(1, 1, 1);
    checkColumns("clear", 0, 0, 0, 0);
    set_activations(4, 0, 0, 0);
    applyStimulus(0, 1, 0);
    set_activations(0, 0, 0, 0);
    applyStimulus(0, 1, 0);
    set_partials(0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1);
    checkColumns("clear_new_weight", 0, 16'd20, 0, 0);

    // Wrap: 0x100*0x100 truncates to 0; 0xFFFF + 2 wraps to 1.
    stage_all_weights_zero();
    stage_weight(0, 16'h0100);
    stage_weight(1, 16'h0001);
    applyStimulus(0, 0, 0);
    set_activations(2, 0, 0, 0);
    applyStimulus(0, 1, 0);
    set_activations(16'h0100, 0, 0, 0);
    applyStimulus(0, 1, 0);
    set_activations(0, 0, 0, 0);
    set_partials(16'd5, 16'hFFFF, 0, 0);
    repeat (4) applyStimulus(0, 0, 1);
    checkColumns("wrap", 16'h0005, 16'h0001, 0, 0);

    // Both enables together: the first MAC must use the old (zero) activation.
    applyStimulus(1, 0, 0);
    stage_all_weights_zero();
    stage_weight(0, 16'd3);
    applyStimulus(0, 0, 0);
    set_activations(5, 0, 0, 0);
    set_partials(1, 0, 0, 0);
    applyStimulus(0, 1, 1);
    set_activations(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1);
    checkOutput("simul_old_a col0", bus.ps_bottom_out_flat[0], 16'd1);
    applyStimulus(0, 0, 1);
    checkOutput("simul_new_a col0", bus.ps_bottom_out_flat[0], 16'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
